// File: rtl/ctr_sched_pkg.sv
// rtl/ctr_sched_pkg.sv - shared types, direction codes and first-set-bit helper for the counter scheduler
package ctr_sched_pkg;

  localparam int MAX_CELLS = 16;
  localparam int IDX_W     = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic DIR_P = 1'b0;
  localparam logic DIR_M = 1'b1;

  function automatic logic [IDX_W-1:0] first_set(input logic [MAX_CELLS-1:0] vec);
    first_set = '0;
    for (int i = MAX_CELLS - 1; i >= 0; i--) begin
      if (vec[i]) first_set = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/ctr_cell_latch.sv
// rtl/ctr_cell_latch.sv - per-cell plus/minus pending latch with cancel, lost detect, grant clear and restore
module ctr_cell_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic req_p,
  input  logic req_m,
  input  logic grant_clr,
  input  logic restore_p,
  input  logic restore_m,
  output logic pend_p,
  output logic pend_m,
  output logic lost
);
  logic pend_p_q, pend_p_d;
  logic pend_m_q, pend_m_d;
  logic base_p, base_m;

  always_comb begin
    base_p = pend_p_q & ~grant_clr;
    base_m = pend_m_q & ~grant_clr;
    lost   = 1'b0;
    // A timeout restore behaves like a pulse applied ahead of this cycle's external pulses.
    if (restore_p) begin
      if (base_p)      lost   = 1'b1;
      else if (base_m) base_m = 1'b0;
      else             base_p = 1'b1;
    end else if (restore_m) begin
      if (base_m)      lost   = 1'b1;
      else if (base_p) base_p = 1'b0;
      else             base_m = 1'b1;
    end
    pend_p_d = base_p;
    pend_m_d = base_m;
    if (req_p && !req_m) begin
      if (base_p)      lost     = 1'b1;
      else if (base_m) pend_m_d = 1'b0;
      else             pend_p_d = 1'b1;
    end else if (req_m && !req_p) begin
      if (base_m)      lost     = 1'b1;
      else if (base_p) pend_p_d = 1'b0;
      else             pend_m_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_p_q <= 1'b0;
      pend_m_q <= 1'b0;
    end else begin
      pend_p_q <= pend_p_d;
      pend_m_q <= pend_m_d;
    end
  end

  assign pend_p = pend_p_q;
  assign pend_m = pend_m_q;

endmodule

// File: rtl/ctr_incr_scheduler.sv
// rtl/ctr_incr_scheduler.sv - schedules involuntary counter increments into the AGC counter-cell interface
// Define CTR_RR_PRIORITY_EN for round-robin winner search; default is fixed lowest-index priority.
module ctr_incr_scheduler
  import ctr_sched_pkg::*;
#(
  parameter int NCELL   = 8,
  parameter int TMO_CYC = 64
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST_n,
  input  logic             CTR_EN,
  input  logic [NCELL-1:0] REQ_P,
  input  logic [NCELL-1:0] REQ_M,
  input  logic             CTR_ACK,
  input  logic             CLR_ERR,
  output logic [NCELL-1:0] CSEL,
  output logic             PINC,
  output logic             MINC,
  output logic             BUSY,
  output logic [NCELL-1:0] PEND,
  output logic             CTR_LOST,
  output logic             CTR_TMO
);
  localparam int            TW       = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  state_e           state_q, state_d;
  logic [NCELL-1:0] csel_q, csel_d;
  logic             pinc_q, pinc_d, minc_q, minc_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             lost_q, lost_d, tmo_q, tmo_d;

  logic [NCELL-1:0] pend_p, pend_m, pend_any, cell_lost;
  logic [NCELL-1:0] grant_clr, restore_p, restore_m, win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_dir, grant_go, tmo_fire;

  assign pend_any = pend_p | pend_m;
  assign grant_go = (state_q == ST_IDLE) && CTR_EN && (|pend_any);

`ifdef CTR_RR_PRIORITY_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] rr_start;
  logic [NCELL-1:0] rr_rot;
  logic [IDX_W:0]   rr_sum;

  // Rotate so the search begins one past the last granted cell, then undo the rotation.
  always_comb begin
    rr_start = (ptr_q == IDX_W'(NCELL - 1)) ? '0 : ptr_q + IDX_W'(1);
    for (int i = 0; i < NCELL; i++) rr_rot[i] = pend_any[(i + int'(rr_start)) % NCELL];
    rr_sum  = {1'b0, first_set(MAX_CELLS'(rr_rot))} + {1'b0, rr_start};
    win_idx = (rr_sum >= (IDX_W+1)'(NCELL)) ? IDX_W'(rr_sum - (IDX_W+1)'(NCELL)) : rr_sum[IDX_W-1:0];
    ptr_d   = grant_go ? win_idx : ptr_q;
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST_n) ptr_q <= IDX_W'(NCELL - 1);
    else            ptr_q <= ptr_d;
  end
`else
  assign win_idx = first_set(MAX_CELLS'(pend_any));
`endif

  assign win_oh  = NCELL'(1) << win_idx;
  assign win_dir = (|(win_oh & pend_p)) ? DIR_P : DIR_M;

  always_comb begin
    state_d   = state_q;
    csel_d    = csel_q;
    pinc_d    = pinc_q;
    minc_d    = minc_q;
    tmo_cnt_d = tmo_cnt_q;
    grant_clr = '0;
    tmo_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_go) begin
          state_d   = ST_GRANT;
          csel_d    = win_oh;
          pinc_d    = (win_dir == DIR_P);
          minc_d    = (win_dir == DIR_M);
          tmo_cnt_d = '0;
          grant_clr = win_oh;
        end
      end
      ST_GRANT: begin
        if (CTR_ACK || (tmo_cnt_q == TMO_LAST)) begin
          tmo_fire  = !CTR_ACK;
          state_d   = ST_IDLE;
          csel_d    = '0;
          pinc_d    = 1'b0;
          minc_d    = 1'b0;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    lost_d = (lost_q & ~CLR_ERR) | (|cell_lost);
    tmo_d  = (tmo_q & ~CLR_ERR) | tmo_fire;
  end

  assign restore_p = (tmo_fire && pinc_q) ? csel_q : '0;
  assign restore_m = (tmo_fire && minc_q) ? csel_q : '0;

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST_n) begin
      state_q   <= ST_IDLE;
      csel_q    <= '0;
      pinc_q    <= 1'b0;
      minc_q    <= 1'b0;
      tmo_cnt_q <= '0;
      lost_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      csel_q    <= csel_d;
      pinc_q    <= pinc_d;
      minc_q    <= minc_d;
      tmo_cnt_q <= tmo_cnt_d;
      lost_q    <= lost_d;
      tmo_q     <= tmo_d;
    end
  end

  for (genvar i = 0; i < NCELL; i++) begin : g_cell
    ctr_cell_latch u_latch (
      .clk       (SIM_CLK),
      .rst_n     (SIM_RST_n),
      .req_p     (REQ_P[i]),
      .req_m     (REQ_M[i]),
      .grant_clr (grant_clr[i]),
      .restore_p (restore_p[i]),
      .restore_m (restore_m[i]),
      .pend_p    (pend_p[i]),
      .pend_m    (pend_m[i]),
      .lost      (cell_lost[i])
    );
  end

  assign CSEL     = csel_q;
  assign PINC     = pinc_q;
  assign MINC     = minc_q;
  assign BUSY     = (state_q == ST_GRANT);
  assign PEND     = pend_any;
  assign CTR_LOST = lost_q;
  assign CTR_TMO  = tmo_q;

endmodule

// File: tb/tb_ctr_incr_scheduler.sv
// tb/tb_ctr_incr_scheduler.sv - bench for ctr_incr_scheduler: vector table, directed corners, random vs model
module tb_ctr_incr_scheduler;
  localparam int NCELL   = 8;
  localparam int TMO_CYC = 64;

  logic             clk = 1'b0;
  logic             SIM_RST_n = 1'b0, CTR_EN = 1'b0, CTR_ACK = 1'b0, CLR_ERR = 1'b0;
  logic [NCELL-1:0] REQ_P = '0, REQ_M = '0;
  logic [NCELL-1:0] CSEL, PEND;
  logic             PINC, MINC, BUSY, CTR_LOST, CTR_TMO;

  always #5 clk = ~clk;

  ctr_incr_scheduler #(.NCELL(NCELL), .TMO_CYC(TMO_CYC)) dut (
    .SIM_CLK(clk), .SIM_RST_n(SIM_RST_n), .CTR_EN(CTR_EN), .REQ_P(REQ_P), .REQ_M(REQ_M),
    .CTR_ACK(CTR_ACK), .CLR_ERR(CLR_ERR), .CSEL(CSEL), .PINC(PINC), .MINC(MINC), .BUSY(BUSY),
    .PEND(PEND), .CTR_LOST(CTR_LOST), .CTR_TMO(CTR_TMO)
  );

  wire [20:0] dut_vec = {CSEL, PINC, MINC, BUSY, PEND, CTR_LOST, CTR_TMO};

  int checks = 0, errors = 0, cyc_n = 0;

  // Model: each cell holds a net count in {-1,0,+1}; a pulse that would push it past 1 is lost.
  int m_pend[NCELL];
  bit m_busy = 0, m_lost = 0, m_tmo = 0, m_lost_ev = 0;
  int m_cell = 0, m_dir = 0, m_cnt = 0, m_last = NCELL - 1;

  function automatic void m_apply(int c, int d);
    if (m_pend[c] == d) m_lost_ev = 1'b1;
    else m_pend[c] += d;
  endfunction

  function automatic int m_pick();
    for (int k = 1; k <= NCELL; k++) begin
`ifdef CTR_RR_PRIORITY_EN
      int c = (m_last + k) % NCELL;
`else
      int c = k - 1;
`endif
      if (m_pend[c] != 0) return c;
    end
    return -1;
  endfunction

  function automatic void m_step(logic rst_n, logic en, logic [NCELL-1:0] p, logic [NCELL-1:0] m,
                                 logic ack, logic clr);
    bit tmo_ev = 1'b0;
    int win;
    if (!rst_n) begin
      for (int i = 0; i < NCELL; i++) m_pend[i] = 0;
      m_busy = 0; m_lost = 0; m_tmo = 0; m_cnt = 0; m_last = NCELL - 1;
      return;
    end
    m_lost_ev = 1'b0;
    if (m_busy) begin
      if (ack) m_busy = 0;
      else if (m_cnt == TMO_CYC - 1) begin
        tmo_ev = 1'b1;
        m_busy = 0;
        m_apply(m_cell, m_dir);
      end else m_cnt++;
    end else if (en) begin
      win = m_pick();
      if (win >= 0) begin
        m_dir = m_pend[win]; m_pend[win] = 0;
        m_cell = win; m_busy = 1; m_cnt = 0; m_last = win;
      end
    end
    for (int i = 0; i < NCELL; i++)
      if (p[i] != m[i]) m_apply(i, p[i] ? 1 : -1);
    m_lost = (m_lost && !clr) || m_lost_ev;
    m_tmo  = (m_tmo && !clr) || tmo_ev;
  endfunction

  function automatic logic [20:0] model_vec();
    logic [NCELL-1:0] cs = '0, pd = '0;
    if (m_busy) cs[m_cell] = 1'b1;
    for (int i = 0; i < NCELL; i++) pd[i] = (m_pend[i] != 0);
    return {cs, m_busy && m_dir > 0, m_busy && m_dir < 0, m_busy, pd, m_lost, m_tmo};
  endfunction

  task automatic cyc(input logic rst_n, input logic en, input logic [NCELL-1:0] p,
                     input logic [NCELL-1:0] m, input logic ack, input logic clr);
    SIM_RST_n = rst_n; CTR_EN = en; REQ_P = p; REQ_M = m; CTR_ACK = ack; CLR_ERR = clr;
    @(posedge clk);
    m_step(rst_n, en, p, m, ack, clr);
    #1;
    cyc_n++;
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL model cyc=%0d got=%h want=%h", cyc_n, dut_vec, model_vec());
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic grant_one(output logic [NCELL-1:0] sel);
    sel = '0;
    for (int n = 0; n < 8 && sel == '0; n++) begin
      cyc(1, 1, '0, '0, 0, 0);
      if (BUSY) sel = CSEL;
    end
    cyc(1, 1, '0, '0, 1, 0);
  endtask

  typedef struct packed {
    logic rst_n, en; logic [7:0] p, m; logic ack, clr;
    logic [7:0] csel; logic pinc, minc, busy; logic [7:0] pend; logic lost, tmo;
  } vec_t;

  vec_t tbl[$];
  logic [NCELL-1:0] sel;
  int exp_ord[3];
  int ack_pct;

  initial begin
    //                rst en  p      m      ack clr  csel   pi mi bs pend   lo to
    tbl.push_back('{1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,8'h00,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,8'h08,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h08,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,8'h00,8'h00,1'b0,1'b0,8'h08,1'b1,1'b0,1'b1,8'h00,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,8'h00,8'h00,1'b0,1'b0,8'h08,1'b1,1'b0,1'b1,8'h00,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,8'h04,8'h04,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,8'h20,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h20,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h20,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,8'h00,8'h20,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,8'h00,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,8'h00,8'h02,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h02,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,8'h00,8'h02,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h02,1'b1,1'b0});
    tbl.push_back('{1'b1,1'b0,8'h00,8'h00,1'b0,1'b1,8'h00,1'b0,1'b0,1'b0,8'h02,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,8'h00,8'h00,1'b0,1'b0,8'h02,1'b0,1'b1,1'b1,8'h00,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,8'h01,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h01,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,8'h01,8'h00,1'b0,1'b1,8'h00,1'b0,1'b0,1'b0,8'h01,1'b1,1'b0});
    tbl.push_back('{1'b1,1'b0,8'h00,8'h00,1'b0,1'b1,8'h00,1'b0,1'b0,1'b0,8'h01,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b0,8'h00,8'h01,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0});

    foreach (tbl[r]) begin
      cyc(tbl[r].rst_n, tbl[r].en, tbl[r].p, tbl[r].m, tbl[r].ack, tbl[r].clr);
      checks++;
      if (dut_vec !== {tbl[r].csel, tbl[r].pinc, tbl[r].minc, tbl[r].busy, tbl[r].pend,
                       tbl[r].lost, tbl[r].tmo}) begin
        errors++;
        $display("FAIL tbl row=%0d got=%h want=%h", r, dut_vec,
                 {tbl[r].csel, tbl[r].pinc, tbl[r].minc, tbl[r].busy, tbl[r].pend, tbl[r].lost, tbl[r].tmo});
      end
    end

    // Grant order: cell 4 alone first, then {0,4,6} together.
    cyc(1, 0, 8'h10, '0, 0, 0);
    grant_one(sel);
    chk("order_first", 32'(sel), 32'h10);
    cyc(1, 0, 8'h51, '0, 0, 0);
`ifdef CTR_RR_PRIORITY_EN
    exp_ord = '{6, 0, 4};
`else
    exp_ord = '{0, 4, 6};
`endif
    for (int k = 0; k < 3; k++) begin
      grant_one(sel);
      chk($sformatf("order_%0d", k), 32'(sel), 32'(1) << exp_ord[k]);
    end

    // Timeout on cell 7, restore, re-grant, then ack on the expiring cycle.
    cyc(1, 0, 8'h80, '0, 0, 0);
    cyc(1, 1, '0, '0, 0, 0);
    chk("tmo_grant", 32'(CSEL), 32'h80);
    for (int n = 0; n < TMO_CYC - 1; n++) cyc(1, 1, '0, '0, 0, 0);
    chk("tmo_still_busy", {30'd0, BUSY, CTR_TMO}, 32'h2);
    cyc(1, 1, '0, '0, 0, 0);
    chk("tmo_fire", {22'd0, BUSY, CTR_TMO, PEND}, 32'h180);
    cyc(1, 1, '0, '0, 0, 1);
    chk("tmo_regrant", {22'd0, BUSY, CTR_TMO, CSEL}, 32'h280);
    for (int n = 0; n < TMO_CYC - 1; n++) cyc(1, 1, '0, '0, 0, 0);
    cyc(1, 1, '0, '0, 1, 0);
    chk("ack_beats_tmo", {22'd0, BUSY, CTR_TMO, PEND}, 32'h0);

    // Reset while granted with cells 4..7 still pending.
    cyc(1, 0, 8'hF1, '0, 0, 0);
    cyc(1, 1, '0, '0, 0, 0);
    chk("pre_rst", {23'd0, BUSY, PEND}, 32'h1F0);
    cyc(0, 1, '0, '0, 0, 0);
    chk("rst_mid_grant", {15'd0, CSEL, BUSY, PEND}, 32'h0);
    cyc(1, 1, '0, '0, 1, 0);
    chk("late_ack", 32'(dut_vec), 32'h0);

    ack_pct = 35;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) ack_pct = (ack_pct == 2) ? 35 : 2;
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
          NCELL'($urandom & $urandom & $urandom), NCELL'($urandom & $urandom & $urandom),
          $urandom_range(0, 99) < ack_pct, $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc_n);
    $fatal(1);
  end

endmodule

// File: doc/ctr_incr_scheduler.md
Name: ctr_incr_scheduler

Overview:
- Schedules involuntary counter-increment requests (PIPA, CDU, timer pulses) into the AGC counter-cell interface.
- Latches plus and minus pulses per counter cell and cancels opposite pairs.
- Selects one cell at a time, drives the one-hot cell select and PINC/MINC to the AGC, and holds them until the AGC acknowledges the counter cycle.
- Sits between external pulse sources and the AGC top-level counter inputs.

Parameters:
- NCELL, 8: number of counter cells served (1..16).
- TMO_CYC, 64: cycles allowed in GRANT before a timeout is declared (≥2).

Ports:
- SIM_CLK  in  1  sole clock, rising edge.
- SIM_RST_n  in  1  synchronous reset, active-low.
- CTR_EN  in  1  scheduling enable; 0 blocks new grants only.
- REQ_P  in  NCELL  one-cycle plus-increment pulses, one bit per cell.
- REQ_M  in  NCELL  one-cycle minus-increment pulses, one bit per cell.
- CTR_ACK  in  1  one-cycle pulse from the AGC: counter cycle for the granted cell done.
- CSEL  out  NCELL  one-hot selected cell; zero when idle.
- PINC  out  1  granted operation is a plus increment.
- MINC  out  1  granted operation is a minus increment.
- BUSY  out  1  in GRANT state.
- PEND  out  NCELL  per-cell pending, plus or minus.
- CTR_LOST  out  1  sticky: a pulse hit an already-pending same-direction latch.
- CTR_TMO  out  1  sticky: GRANT timed out.
- CLR_ERR  in  1  clears CTR_LOST and CTR_TMO.

Behaviour:
- Reset (SIM_RST_n=0 at an edge): all pending latches clear, state IDLE, CSEL=0, PINC=MINC=BUSY=0, CTR_LOST=CTR_TMO=0, timeout counter 0. Reset mid-GRANT abandons the grant with no ack expected.
- Pending latches, updated per cell each edge:
  - REQ_P with plus-pending already set: CTR_LOST=1, latch unchanged.
  - REQ_P with minus-pending set: minus-pending clears (cancel), no plus is set.
  - REQ_P and REQ_M in the same cycle: no change.
  - REQ_M is symmetric to REQ_P.
- State IDLE: if CTR_EN and any pending, pick a winner and enter GRANT at the next edge.
  - CSEL/PINC/MINC/BUSY are registered and valid in the first GRANT cycle.
  - Latency: pulse at edge t → pending at t+1 → CSEL valid after edge t+2.
- Winner selection: lowest-index pending cell. Direction is whichever latch is set; cancellation guarantees at most one.
- At grant, the winner's pending latch clears. A new pulse for the granted cell during GRANT re-latches normally and is served in a later grant.
- State GRANT: outputs are held stable.
  - CTR_ACK → IDLE at the next edge, outputs zero.
  - CTR_ACK in IDLE is ignored.
  - IDLE with pending re-grants after one IDLE cycle (minimum 1 idle cycle between grants).
- Timeout: the counter increments each GRANT cycle. Reaching TMO_CYC without ack → CTR_TMO=1, the lost operation's latch is re-set (restored), state IDLE.
  - Restore with a same-direction pulse in the same cycle: latch set, CTR_LOST=1.
  - Restore with an opposite-direction pulse in the same cycle: they cancel.
- CTR_ACK on the same edge the count expires: ack wins, no timeout.
- CTR_EN=0 during GRANT: the current grant completes normally.
- CLR_ERR: clears both stickies. A same-cycle set event wins.

Optional Feature:
- Macro CTR_RR_PRIORITY_EN.
- Defined: round-robin selection. The search starts at index (last granted + 1) mod NCELL and wraps; the pointer resets to NCELL-1, so cell 0 is first after reset.
- Undefined: fixed lowest-index priority as above.

Decomposition:
- Package ctr_sched_pkg: state enum (ST_IDLE, ST_GRANT), direction constants DIR_P/DIR_M, and a first-set-bit helper function.
- One sub-module, ctr_cell_latch, instantiated NCELL times: the per-cell plus/minus pending latch with cancel, lost detect, grant-clear and timeout-restore inputs.

Test Plan:
1. Reset → all outputs 0. REQ_P[3] pulse at cycle 10 → CSEL=0x08, PINC=1 at cycle 12; CTR_ACK at cycle 15 → CSEL=0 at cycle 16.
2. REQ_P[2] and REQ_M[2] in the same cycle → PEND stays 0, no grant. REQ_P[5] then REQ_M[5] two cycles later → PEND[5] clears, no grant (hold CTR_EN=0 during the pulses).
3. REQ_M[1] twice while pending, CTR_EN=0 → CTR_LOST=1, PEND=0x02. CLR_ERR → CTR_LOST=0.
4. Pending cells {0,4,6}, CTR_EN=1, immediate acks → grant order 0,4,6 (fixed). With CTR_RR_PRIORITY_EN, last granted 4 and all three re-pended → order 6,0,4.
5. Grant cell 7, withhold ack 64 cycles → CTR_TMO=1, IDLE, PEND[7]=1, re-grant of cell 7 follows.
6. SIM_RST_n=0 mid-GRANT with PEND=0xF0 → next cycle CSEL=0, PEND=0, BUSY=0. A late CTR_ACK is ignored.
